// File: rtl/bellek_hakemi.sv
// Round-robin arbiter between instruction-cache and data-cache refill/write
// ports and the single iomem bus; line reads are bursts, writes are single words.
module bellek_hakemi #(
  parameter int unsigned HAT_KELIME = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bo_istek_i,
  input  logic [31:0] bo_adres_i,
  output logic [31:0] bo_veri_o,
  output logic        bo_gecerli_o,
  output logic        bo_bitti_o,
  input  logic        vo_istek_i,
  input  logic        vo_yaz_i,
  input  logic [31:0] vo_adres_i,
  input  logic [31:0] vo_yaz_veri_i,
  input  logic [3:0]  vo_wstrb_i,
  output logic [31:0] vo_veri_o,
  output logic        vo_gecerli_o,
  output logic        vo_bitti_o,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  localparam int unsigned KW  = $clog2(HAT_KELIME);
  localparam int unsigned OFS = KW + 2;
  localparam logic [KW-1:0] K_SON = KW'(HAT_KELIME - 1);

  typedef enum logic [1:0] {BOSTA, OKU, YAZ, BITIS} durum_t;

  durum_t          durum_q, durum_d;
  logic            son_q, son_d;       // last grantee: 1 = data cache
  logic            sahip_q, sahip_d;   // current grantee: 1 = data cache
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   k_art;
  logic [31:OFS]   hat_q, hat_d;
  logic            bo_sec, vo_sec;

  logic            valid_d;
  logic [3:0]      wstrb_d;
  logic [31:0]     addr_d, wdata_d;
  logic [31:0]     bo_veri_d, vo_veri_d;
  logic            bo_gecerli_d, bo_bitti_d, vo_gecerli_d, vo_bitti_d;

  // Line-offset bits of the request addresses are ignored by design.
  logic unused_adres;
  assign unused_adres = ^{bo_adres_i[OFS-1:0], vo_adres_i[1:0]};

  always_comb begin
    durum_d      = durum_q;
    son_d        = son_q;
    sahip_d      = sahip_q;
    k_d          = k_q;
    hat_d        = hat_q;
    valid_d      = iomem_valid;
    addr_d       = iomem_addr;
    wstrb_d      = iomem_wstrb;
    wdata_d      = iomem_wdata;
    bo_veri_d    = bo_veri_o;
    vo_veri_d    = vo_veri_o;
    bo_gecerli_d = 1'b0;
    bo_bitti_d   = 1'b0;
    vo_gecerli_d = 1'b0;
    vo_bitti_d   = 1'b0;
    k_art        = k_q + 1'b1;
    bo_sec       = bo_istek_i && (!vo_istek_i || son_q);
    vo_sec       = vo_istek_i && !bo_sec;

    case (durum_q)
      BOSTA: begin
        if (bo_sec) begin
          sahip_d = 1'b0;
          son_d   = 1'b0;
          hat_d   = bo_adres_i[31:OFS];
          k_d     = '0;
          valid_d = 1'b1;
          addr_d  = {bo_adres_i[31:OFS], {OFS{1'b0}}};
          wstrb_d = '0;
          wdata_d = '0;
          durum_d = OKU;
        end else if (vo_sec) begin
          sahip_d = 1'b1;
          son_d   = 1'b1;
          k_d     = '0;
          valid_d = 1'b1;
          if (vo_yaz_i) begin
            addr_d  = {vo_adres_i[31:2], 2'b00};
            wdata_d = vo_yaz_veri_i;
            wstrb_d = vo_wstrb_i;
            durum_d = YAZ;
          end else begin
            hat_d   = vo_adres_i[31:OFS];
            addr_d  = {vo_adres_i[31:OFS], {OFS{1'b0}}};
            wstrb_d = '0;
            wdata_d = '0;
            durum_d = OKU;
          end
        end
      end
      OKU: begin
        if (iomem_ready) begin
          if (sahip_q) begin
            vo_veri_d    = iomem_rdata;
            vo_gecerli_d = 1'b1;
          end else begin
            bo_veri_d    = iomem_rdata;
            bo_gecerli_d = 1'b1;
          end
          if (k_q == K_SON) begin
            valid_d = 1'b0;
            addr_d  = '0;
            k_d     = '0;
            durum_d = BITIS;
            if (sahip_q) vo_bitti_d = 1'b1;
            else         bo_bitti_d = 1'b1;
          end else begin
            // offset field is exactly KW bits wide, so the line is never crossed
            k_d    = k_art;
            addr_d = {hat_q, k_art, 2'b00};
          end
        end
      end
      YAZ: begin
        if (iomem_ready) begin
          valid_d    = 1'b0;
          addr_d     = '0;
          wdata_d    = '0;
          wstrb_d    = '0;
          vo_bitti_d = 1'b1;
          durum_d    = BITIS;
        end
      end
      BITIS: durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q      <= BOSTA;
      son_q        <= 1'b1;
      sahip_q      <= 1'b0;
      k_q          <= '0;
      hat_q        <= '0;
      iomem_valid  <= 1'b0;
      iomem_addr   <= '0;
      iomem_wstrb  <= '0;
      iomem_wdata  <= '0;
      bo_veri_o    <= '0;
      vo_veri_o    <= '0;
      bo_gecerli_o <= 1'b0;
      bo_bitti_o   <= 1'b0;
      vo_gecerli_o <= 1'b0;
      vo_bitti_o   <= 1'b0;
    end else begin
      durum_q      <= durum_d;
      son_q        <= son_d;
      sahip_q      <= sahip_d;
      k_q          <= k_d;
      hat_q        <= hat_d;
      iomem_valid  <= valid_d;
      iomem_addr   <= addr_d;
      iomem_wstrb  <= wstrb_d;
      iomem_wdata  <= wdata_d;
      bo_veri_o    <= bo_veri_d;
      vo_veri_o    <= vo_veri_d;
      bo_gecerli_o <= bo_gecerli_d;
      bo_bitti_o   <= bo_bitti_d;
      vo_gecerli_o <= vo_gecerli_d;
      vo_bitti_o   <= vo_bitti_d;
    end
  end

endmodule

// File: tb/tb_bellek_hakemi.sv
// Bench for bellek_hakemi: table of single-requester transactions plus
// hand sequences for arbitration, back-to-back grants and mid-burst reset.
module tb_bellek_hakemi;
  localparam int unsigned HAT = 4;

  typedef logic [136:0] deger_t;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        yaz;
    logic        sahip;
    logic        son;
  } vuru_t;

  typedef struct {
    logic        sahip;
    logic        yaz;
    logic [31:0] adres;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          mod;
    int          gecikme;
    logic [31:0] ilk_adr;
    int          vuru;
    int          sure;
  } vektor_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        bo_istek_i = 1'b0;
  logic [31:0] bo_adres_i = '0;
  logic [31:0] bo_veri_o;
  logic        bo_gecerli_o, bo_bitti_o;
  logic        vo_istek_i = 1'b0;
  logic        vo_yaz_i = 1'b0;
  logic [31:0] vo_adres_i = '0;
  logic [31:0] vo_yaz_veri_i = '0;
  logic [3:0]  vo_wstrb_i = '0;
  logic [31:0] vo_veri_o;
  logic        vo_gecerli_o, vo_bitti_o;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata;
  logic [31:0] iomem_rdata = '0;

  bellek_hakemi #(.HAT_KELIME(HAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .bo_istek_i(bo_istek_i), .bo_adres_i(bo_adres_i), .bo_veri_o(bo_veri_o),
    .bo_gecerli_o(bo_gecerli_o), .bo_bitti_o(bo_bitti_o),
    .vo_istek_i(vo_istek_i), .vo_yaz_i(vo_yaz_i), .vo_adres_i(vo_adres_i),
    .vo_yaz_veri_i(vo_yaz_veri_i), .vo_wstrb_i(vo_wstrb_i), .vo_veri_o(vo_veri_o),
    .vo_gecerli_o(vo_gecerli_o), .vo_bitti_o(vo_bitti_o),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
  );

  initial forever #5 clk_i = ~clk_i;

  int dogrulama = 0;
  int hata = 0;

  vuru_t       sb_q[$];
  logic [31:0] bo_q[$];
  logic [31:0] vo_q[$];

  logic        izle = 1'b0;
  int          mod = 0;
  int          gecikme = 1;
  int          bekleme = 0;
  int          valid_sure = 0;
  int          bo_gec_say = 0;
  int          vo_gec_say = 0;
  logic [3:0]  bek_strobe = '0;
  logic        onceki_bekle = 1'b0;
  logic [67:0] onceki_bus = '0;

  function automatic logic [31:0] bellek(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h0F1E_2D3C;
  endfunction

  function automatic deger_t cikislar();
    return {bo_veri_o, bo_gecerli_o, bo_bitti_o, vo_veri_o, vo_gecerli_o, vo_bitti_o,
            iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata};
  endfunction

  task automatic kontrol(input string ad, input deger_t gercek, input deger_t beklenen);
    dogrulama++;
    if (gercek !== beklenen) begin
      hata++;
      $display("FAIL %s: got %0h, expected %0h", ad, gercek, beklenen);
    end
  endtask

  task automatic hata_bildir(input string ad, input string neden);
    dogrulama++;
    hata++;
    $display("FAIL %s: %s", ad, neden);
  endtask

  task automatic kenar();
    @(negedge clk_i);
    #1;
  endtask

  task automatic hat_bekle(input logic [31:0] ilk, input logic sahip, input logic yaz,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    int n;
    vuru_t v;
    n = yaz ? 1 : int'(HAT);
    for (int i = 0; i < n; i++) begin
      v.adr   = ilk + 32'(4 * i);
      v.wstrb = yaz ? wstrb : 4'h0;
      v.wdata = wdata;
      v.yaz   = yaz;
      v.sahip = sahip;
      v.son   = (i == n - 1);
      sb_q.push_back(v);
    end
  endtask

  task automatic bitti_bekle(input logic sahip);
    logic tamam;
    tamam = 1'b0;
    for (int i = 0; i < 300 && !tamam; i++) begin
      kenar();
      if (sahip ? vo_bitti_o : bo_bitti_o) tamam = 1'b1;
    end
    if (!tamam) hata_bildir(sahip ? "vo_bitti_sure" : "bo_bitti_sure", "no bitti within 300 cycles, expected one");
  endtask

  task automatic sifirla();
    izle = 1'b0;
    bo_istek_i = 1'b0;
    vo_istek_i = 1'b0;
    rst_i = 1'b0;
    sb_q.delete();
    bo_q.delete();
    vo_q.delete();
    repeat (3) kenar();
    rst_i = 1'b1;
    izle = 1'b1;
    kenar();
  endtask

  // Bus responder and scoreboard checker; runs on the falling edge.
  initial begin
    vuru_t v;
    forever begin
      @(negedge clk_i);
      if (!izle) begin
        bek_strobe   = '0;
        onceki_bekle = 1'b0;
        bekleme      = 0;
        iomem_ready  = 1'b0;
      end else begin
        if (bek_strobe != 4'h0 || {bo_gecerli_o, bo_bitti_o, vo_gecerli_o, vo_bitti_o} != 4'h0)
          kontrol("strobe", deger_t'({bo_gecerli_o, bo_bitti_o, vo_gecerli_o, vo_bitti_o}),
                  deger_t'(bek_strobe));
        if (bo_gecerli_o) begin
          bo_gec_say++;
          if (bo_q.size() == 0) hata_bildir("bo_veri", "strobe with no word pending");
          else kontrol("bo_veri", deger_t'(bo_veri_o), deger_t'(bo_q.pop_front()));
        end
        if (vo_gecerli_o) begin
          vo_gec_say++;
          if (vo_q.size() == 0) hata_bildir("vo_veri", "strobe with no word pending");
          else kontrol("vo_veri", deger_t'(vo_veri_o), deger_t'(vo_q.pop_front()));
        end
        bek_strobe = '0;
        if (iomem_valid && onceki_bekle)
          kontrol("durgun_bus", deger_t'({iomem_addr, iomem_wdata, iomem_wstrb}), deger_t'(onceki_bus));
        if (iomem_valid) valid_sure++;

        if (!iomem_valid) iomem_ready = 1'b0;
        else if (mod == 0) iomem_ready = 1'b1;
        else if (mod == 1) iomem_ready = (bekleme >= gecikme - 1);
        else iomem_ready = ($urandom_range(0, 2) == 0);
        iomem_rdata = iomem_ready ? bellek(iomem_addr) : 32'hBAD0_BAD0;

        if (iomem_valid && iomem_ready) begin
          bekleme = 0;
          if (sb_q.size() == 0) hata_bildir("bus_vuru", "unexpected bus handshake");
          else begin
            v = sb_q.pop_front();
            kontrol("bus_adr", deger_t'(iomem_addr), deger_t'(v.adr));
            kontrol("bus_wstrb", deger_t'(iomem_wstrb), deger_t'(v.wstrb));
            if (v.yaz) kontrol("bus_wdata", deger_t'(iomem_wdata), deger_t'(v.wdata));
            else if (v.sahip) begin vo_q.push_back(bellek(v.adr)); bek_strobe[1] = 1'b1; end
            else begin bo_q.push_back(bellek(v.adr)); bek_strobe[3] = 1'b1; end
            if (v.son) begin
              if (v.sahip) bek_strobe[0] = 1'b1;
              else         bek_strobe[2] = 1'b1;
            end
          end
        end else if (iomem_valid) bekleme++;
        onceki_bekle = iomem_valid && !iomem_ready;
        onceki_bus   = {iomem_addr, iomem_wdata, iomem_wstrb};
      end
    end
  end

  vektor_t tablo[7];
  vektor_t t;

  initial begin
    tablo[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0,         4'h0, 0, 1, 32'h0000_1230, 4, 4};
    tablo[1] = '{1'b1, 1'b1, 32'h0000_2006, 32'hDEAD_BEEF, 4'h3, 1, 3, 32'h0000_2004, 1, 3};
    tablo[2] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,         4'h0, 2, 1, 32'hFFFF_FFF0, 4, 0};
    tablo[3] = '{1'b1, 1'b1, 32'h0000_3003, 32'h1234_5678, 4'h0, 0, 1, 32'h0000_3000, 1, 1};
    tablo[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         4'h0, 1, 2, 32'hFFFF_FFF0, 4, 8};
    tablo[5] = '{1'b1, 1'b0, 32'h0000_ABCD, 32'h0,         4'h0, 0, 1, 32'h0000_ABC0, 4, 4};
    tablo[6] = '{1'b0, 1'b0, 32'h8000_000C, 32'h0,         4'h0, 2, 1, 32'h8000_0000, 4, 0};

    repeat (3) kenar();
    kontrol("reset_durum", cikislar(), '0);
    rst_i = 1'b1;
    izle = 1'b1;
    kenar();

    for (int i = 0; i < 7; i++) begin
      t = tablo[i];
      mod = t.mod;
      gecikme = t.gecikme;
      valid_sure = 0;
      bo_gec_say = 0;
      vo_gec_say = 0;
      hat_bekle(t.ilk_adr, t.sahip, t.yaz, t.wdata, t.wstrb);
      if (t.sahip) begin
        vo_istek_i = 1'b1; vo_yaz_i = t.yaz; vo_adres_i = t.adres;
        vo_yaz_veri_i = t.wdata; vo_wstrb_i = t.wstrb;
      end else begin
        bo_istek_i = 1'b1; bo_adres_i = t.adres;
      end
      kenar();
      kontrol("gecikme", deger_t'(iomem_valid), deger_t'(1));
      bitti_bekle(t.sahip);
      bo_istek_i = 1'b0;
      vo_istek_i = 1'b0;
      kontrol("gecerli_sayi", deger_t'(t.sahip ? vo_gec_say : bo_gec_say), deger_t'(t.yaz ? 0 : t.vuru));
      if (t.sure != 0) kontrol("bus_sure", deger_t'(valid_sure), deger_t'(t.sure));
      kontrol("sb_bos", deger_t'(sb_q.size()), '0);
      kenar();
    end

    // Mid-burst reset, then a fresh request must restart at word 0.
    mod = 0;
    hat_bekle(32'h0000_5000, 1'b0, 1'b0, '0, '0);
    bo_gec_say = 0;
    bo_istek_i = 1'b1;
    bo_adres_i = 32'h0000_5004;
    for (int i = 0; i < 50 && bo_gec_say == 0; i++) kenar();
    izle = 1'b0;
    rst_i = 1'b0;
    #1;
    kontrol("reset_ani", cikislar(), '0);
    bo_istek_i = 1'b0;
    sb_q.delete(); bo_q.delete(); vo_q.delete();
    kenar(); kenar();
    rst_i = 1'b1;
    izle = 1'b1;
    kenar();
    hat_bekle(32'h0000_5000, 1'b0, 1'b0, '0, '0);
    bo_istek_i = 1'b1;
    bo_adres_i = 32'h0000_500C;
    kenar();
    kontrol("reset_sonra_ilk", deger_t'(iomem_addr), deger_t'(32'h0000_5000));
    bitti_bekle(1'b0);
    bo_istek_i = 1'b0;
    kontrol("sb_bos", deger_t'(sb_q.size()), '0);
    kenar();

    // Simultaneous requests after reset: icache first, then dcache wins against a re-request.
    sifirla();
    hat_bekle(32'h0000_0100, 1'b0, 1'b0, '0, '0);
    hat_bekle(32'h0000_0200, 1'b1, 1'b0, '0, '0);
    bo_istek_i = 1'b1; bo_adres_i = 32'h0000_0104;
    vo_istek_i = 1'b1; vo_yaz_i = 1'b0; vo_adres_i = 32'h0000_0208;
    kenar();
    kontrol("ilk_hakem", deger_t'(iomem_addr), deger_t'(32'h0000_0100));
    bitti_bekle(1'b0);
    hat_bekle(32'h0000_0300, 1'b0, 1'b0, '0, '0);
    bo_adres_i = 32'h0000_030C;
    kenar();
    kontrol("bitis_bosluk", deger_t'(iomem_valid), '0);
    kenar();
    kontrol("rr_hakem", deger_t'({iomem_valid, iomem_addr}), deger_t'({1'b1, 32'h0000_0200}));
    bitti_bekle(1'b1);
    vo_istek_i = 1'b0;
    bitti_bekle(1'b0);
    bo_istek_i = 1'b0;
    kontrol("sb_bos", deger_t'(sb_q.size()), '0);
    kenar();

    // Back-to-back icache requests: BITIS ignores istek, next grant 2 cycles after bitti.
    mod = 0;
    hat_bekle(32'h0000_0400, 1'b0, 1'b0, '0, '0);
    bo_istek_i = 1'b1;
    bo_adres_i = 32'h0000_0404;
    bitti_bekle(1'b0);
    hat_bekle(32'h0000_0500, 1'b0, 1'b0, '0, '0);
    bo_adres_i = 32'h0000_0500;
    kenar();
    kontrol("bitis_yoksay", deger_t'(iomem_valid), '0);
    kenar();
    kontrol("b2b_gecikme", deger_t'({iomem_valid, iomem_addr}), deger_t'({1'b1, 32'h0000_0500}));
    bitti_bekle(1'b0);
    bo_istek_i = 1'b0;
    kontrol("sb_bos", deger_t'(sb_q.size()), '0);
    repeat (2) kenar();

    $display("End of test - %0d assertions evaluated, %0d failures", dogrulama, hata);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bellek_hakemi.md
# bellek_hakemi

Main-memory arbiter between the instruction cache (`bo_*`) and the data cache (`vo_*`) refill and write ports and the single `iomem_*` bus of `user_processor`. It grants one requester at a time using round-robin priority. Read requests run as a full cache-line burst of `HAT_KELIME` words, with each returned word strobed back to the requester. Data-cache write requests run as a single word write with byte strobes.

## Interface
- `HAT_KELIME`, default 4: words per cache line; a power of two, 2..16.
- `clk_i` input, 1 bit: the single clock, rising edge.
- `rst_i` input, 1 bit: reset, asynchronous and active-low.
- `bo_istek_i` input, 1 bit: instruction-cache line read request.
- `bo_adres_i` input, 32 bits: instruction-cache request address; the low line-offset bits are ignored.
- `bo_veri_o` output, 32 bits: returned read word.
- `bo_gecerli_o` output, 1 bit: one-cycle strobe; `bo_veri_o` is valid.
- `bo_bitti_o` output, 1 bit: one-cycle pulse; the instruction-cache request is complete.
- `vo_istek_i` input, 1 bit: data-cache request.
- `vo_yaz_i` input, 1 bit: 1 = single word write, 0 = line read.
- `vo_adres_i` input, 32 bits: data-cache request address; a write uses bits [31:2].
- `vo_yaz_veri_i` input, 32 bits: write data.
- `vo_wstrb_i` input, 4 bits: write byte strobes.
- `vo_veri_o` output, 32 bits: returned read word.
- `vo_gecerli_o` output, 1 bit: one-cycle strobe; `vo_veri_o` is valid.
- `vo_bitti_o` output, 1 bit: one-cycle pulse; the data-cache request is complete.
- `iomem_valid` output, 1 bit: bus request.
- `iomem_ready` input, 1 bit: bus acknowledge.
- `iomem_wstrb` output, 4 bits: bus byte strobes; 0 for reads.
- `iomem_addr` output, 32 bits: bus word address; bits [1:0] are always 0.
- `iomem_wdata` output, 32 bits: bus write data.
- `iomem_rdata` input, 32 bits: bus read data, valid in the cycle `iomem_ready` is high.

## Operation
- **States:**
  - `BOSTA`: idle.
  - `OKU`: line read burst.
  - `YAZ`: single word write.
  - `BITIS`: one-cycle completion.
- **Reset:** all outputs are 0. State is `BOSTA`. The offset counter is 0. The last grant register `son` is set to data, so the instruction cache wins the first tie.
- **BOSTA:** requests are sampled every cycle.
  - Only one requester active: it is granted.
  - Both active: grant the requester that is not `son`.
  - On grant, the next state is `OKU`, or `YAZ` when the data cache has `vo_yaz_i`=1. The grantee's request inputs are latched and `son` is updated.
- **OKU:**
  - Base address is the request address with bits [log2(4·`HAT_KELIME`)-1:0] cleared.
  - The offset counter k runs 0..`HAT_KELIME`-1; `iomem_addr` = base + 4·k.
  - Addresses never cross the line boundary. Line 0xFFFFFFF0 with `HAT_KELIME`=4 issues words 0xFFFFFFF0..0xFFFFFFFC and does not wrap.
  - On each `iomem_ready`: capture `iomem_rdata` and increment k.
  - When k = `HAT_KELIME`-1 is acknowledged: go to `BITIS`.
- **YAZ:** drive the latched address, data and strobes. On `iomem_ready`, go to `BITIS`.
  - `vo_wstrb_i`=0 is forwarded unchanged; it still completes a bus handshake.
- **BITIS:** the grantee's `bitti` pulse is high. Requests are not sampled in this cycle. The next state is `BOSTA`.
- **Requester contract:** hold `istek` and its inputs stable until `bitti`, then deassert `istek` in the cycle after `bitti`.
  - If `istek` is still high in the following `BOSTA` cycle, it is a new request.
  - If `istek` is dropped mid-transaction, the drop is ignored and the transaction runs to completion.
- **Data holding:** `bo_veri_o` and `vo_veri_o` hold their last captured word. They are updated only on the owning requester's read captures.

## Timing
- Outputs are registered; there is no combinational path from any input to any output.
- **Grant latency:** request seen in `BOSTA` at cycle t → `iomem_valid`=1 at t+1.
- **Bus hold:** `iomem_valid` stays high continuously through a burst, until the last `iomem_ready`. `iomem_addr`, `iomem_wdata` and `iomem_wstrb` are stable while `iomem_valid`=1 and no `iomem_ready` has arrived.
- **Address advance:** after `iomem_ready` at cycle c, if words remain, `iomem_addr` advances at c+1 and `iomem_valid` stays 1.
- **Read return:** for a capture at cycle c, `gecerli`=1 with the word at c+1.
  - For the last word, `gecerli` and `bitti` are both high at c+1, the `BITIS` cycle.
  - `iomem_valid`=0 at c+1.
- **Write completion:** for `iomem_ready` at cycle c: `vo_bitti_o`=1 and `vo_gecerli_o`=0 at c+1.
- **Throughput:** minimum line read is `HAT_KELIME`+2 cycles from request to `BITIS` inclusive. Minimum turnaround between two grants is 1 idle cycle (`BITIS`) plus 1 `BOSTA` cycle.
- **Reset mid-burst:** outputs clear immediately (asynchronous assert). After release, the arbiter restarts in `BOSTA` and the interrupted transaction is lost.

## Test plan
- **Instruction line read:** `bo_istek_i`=1, `bo_adres_i`=0x0000_1234, `iomem_ready` always 1 → bus addresses 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles. Expect 4 `bo_gecerli_o` strobes with the matching `iomem_rdata`, `bo_bitti_o` on the 4th, and `iomem_wstrb`=0 throughout.
- **Data write:** `vo_istek_i`=1, `vo_yaz_i`=1, address 0x2006, data 0xDEADBEEF, `vo_wstrb_i`=0x3, with `iomem_ready` delayed 3 cycles → `iomem_addr`=0x2004, `iomem_wdata`=0xDEADBEEF and `iomem_wstrb`=0x3 held for 3 cycles. Then `vo_bitti_o` pulses once, with no `vo_gecerli_o`.
- **Simultaneous requests after reset:** both `istek` high → the instruction cache is served first, then the data cache. Repeat both together → the data cache wins this time (round robin).
- **Random ready stalls:** random `iomem_ready` gaps during a data line read of 0xFFFF_FFF0 → addresses stay stable during stalls and never exceed 0xFFFF_FFFC; exactly 4 `vo_gecerli_o` strobes.
- **Reset mid-burst:** `rst_i`=0 after word 1 of a burst → all outputs are 0 at once. After release, a new `bo` request starts from word 0 of its line.
- **Back-to-back requests:** instruction cache keeps `istek` high through `bitti` while the data cache is idle → the `BITIS` cycle ignores it, and a second grant appears with `iomem_valid` 2 cycles after `bitti`.
